// File: rtl/dual_port_ram_if.sv
// dual_port_ram_if: bundle of the request/response signals of dual_port_ram.
//   init_busy              : RAM-side clear sequence in progress
//   a_en/a_we/a_be/a_addr/a_din -> a_dout/a_valid : read/write port A
//   b_en/b_addr            -> b_dout/b_valid/b_collision : read-only port B
// Modports: master = client driving requests, slave = the RAM itself.
interface dual_port_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int BYTE_WIDTH = 8
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;

  logic                  init_busy;

  logic                  a_en;
  logic                  a_we;
  logic [NB-1:0]         a_be;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_din;
  logic [DATA_WIDTH-1:0] a_dout;
  logic                  a_valid;

  logic                  b_en;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_dout;
  logic                  b_valid;
  logic                  b_collision;

  modport master (
    input  init_busy, a_dout, a_valid, b_dout, b_valid, b_collision,
    output a_en, a_we, a_be, a_addr, a_din, b_en, b_addr
  );

  modport slave (
    output init_busy, a_dout, a_valid, b_dout, b_valid, b_collision,
    input  a_en, a_we, a_be, a_addr, a_din, b_en, b_addr
  );
endinterface

// File: rtl/dual_port_ram.sv
// dual_port_ram: single-clock RAM with a read/write port A and a read-only
// port B. Features byte-lane writes, selectable port-A read-during-write
// behaviour, optional output register, read-valid pulses, cross-port
// collision flag and a post-reset zero-fill of the whole array.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : dual_port_ram_if.slave (requests in, read data/flags out)
module dual_port_ram #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int BYTE_WIDTH     = 8,
  parameter int RDW_MODE       = 0,  // 0 read-first, 1 write-first, 2 no-change
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  dual_port_ram_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // First read stage (always present)
  logic [DATA_WIDTH-1:0] a_dout1_q, a_dout1_d;
  logic                  a_vld1_q, a_vld1_d;
  logic [DATA_WIDTH-1:0] b_dout1_q, b_dout1_d;
  logic                  b_vld1_q, b_vld1_d;
  logic                  b_col1_q, b_col1_d;

  // Optional second stage; bypassed at the output mux when OUT_REG=0
  logic [DATA_WIDTH-1:0] a_dout2_q, a_dout2_d;
  logic                  a_vld2_q, a_vld2_d;
  logic [DATA_WIDTH-1:0] b_dout2_q, b_dout2_d;
  logic                  b_vld2_q, b_vld2_d;
  logic                  b_col2_q, b_col2_d;

  logic                  run;
  logic                  a_acc, a_wr, b_acc;
  logic [DATA_WIDTH-1:0] a_old, a_merged;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // ---------------- clear FSM ----------------
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == '1) state_d = ST_RUN;
      end
      default: ;
    endcase
  end

  assign run           = (state_q == ST_RUN);
  assign bus.init_busy = (state_q == ST_CLEAR);

  // ---------------- request decode ----------------
  assign a_acc = run && bus.a_en;
  assign a_wr  = a_acc && bus.a_we;
  assign b_acc = run && bus.b_en;
  assign a_old = mem[bus.a_addr];

  always_comb begin
    a_merged = a_old;
    for (int i = 0; i < NB; i++) begin
      if (bus.a_be[i]) a_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // The clear sequence borrows the single array write path
  always_comb begin
    mem_we    = a_wr;
    mem_waddr = bus.a_addr;
    mem_wdata = a_merged;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end
  end

  // ---------------- read stages ----------------
  always_comb begin
    a_dout1_d = a_dout1_q;
    a_vld1_d  = 1'b0;
    if (a_acc) begin
      if (!bus.a_we) begin
        a_dout1_d = a_old;
        a_vld1_d  = 1'b1;
      end else begin
        case (RDW_MODE)
          1:       begin a_dout1_d = a_merged; a_vld1_d = 1'b1; end
          2:       ;  // no-change: hold data, no valid
          default: begin a_dout1_d = a_old;    a_vld1_d = 1'b1; end
        endcase
      end
    end

    // B reads the array before this edge's write lands, so a same-address
    // write from A is seen as the old word.
    b_dout1_d = b_acc ? mem[bus.b_addr] : b_dout1_q;
    b_vld1_d  = b_acc;
    b_col1_d  = b_acc && a_wr && (bus.a_addr == bus.b_addr);

    // Second stage only captures data that was valid, so idle cycles hold
    a_dout2_d = a_vld1_q ? a_dout1_q : a_dout2_q;
    a_vld2_d  = a_vld1_q;
    b_dout2_d = b_vld1_q ? b_dout1_q : b_dout2_q;
    b_vld2_d  = b_vld1_q;
    b_col2_d  = b_col1_q;
  end

  // ---------------- registers ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_STATE;
      cnt_q     <= '0;
      a_dout1_q <= '0;
      a_vld1_q  <= 1'b0;
      b_dout1_q <= '0;
      b_vld1_q  <= 1'b0;
      b_col1_q  <= 1'b0;
      a_dout2_q <= '0;
      a_vld2_q  <= 1'b0;
      b_dout2_q <= '0;
      b_vld2_q  <= 1'b0;
      b_col2_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_dout1_q <= a_dout1_d;
      a_vld1_q  <= a_vld1_d;
      b_dout1_q <= b_dout1_d;
      b_vld1_q  <= b_vld1_d;
      b_col1_q  <= b_col1_d;
      a_dout2_q <= a_dout2_d;
      a_vld2_q  <= a_vld2_d;
      b_dout2_q <= b_dout2_d;
      b_vld2_q  <= b_vld2_d;
      b_col2_q  <= b_col2_d;
    end
  end

  // NOTE: the array has no reset so it maps onto block RAM; zeroing is done
  // by the clear sequence instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // ---------------- outputs ----------------
  assign bus.a_dout      = (OUT_REG != 0) ? a_dout2_q : a_dout1_q;
  assign bus.a_valid     = (OUT_REG != 0) ? a_vld2_q  : a_vld1_q;
  assign bus.b_dout      = (OUT_REG != 0) ? b_dout2_q : b_dout1_q;
  assign bus.b_valid     = (OUT_REG != 0) ? b_vld2_q  : b_vld1_q;
  assign bus.b_collision = (OUT_REG != 0) ? b_col2_q  : b_col1_q;
endmodule

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram. Three instances share one stimulus stream:
//   u0: defaults (read-first, no output register)
//   u1: write-first with output register
//   u2: no-change read-during-write
// A bench-side memory model feeds per-instance scoreboard queues; a vector
// table adds hand-derived expectations for the default instance.
module tb_dual_port_ram;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dual_port_ram_if bus0 ();
  dual_port_ram_if bus1 ();
  dual_port_ram_if bus2 ();

  dual_port_ram #(.RDW_MODE(0), .OUT_REG(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  dual_port_ram #(.RDW_MODE(1), .OUT_REG(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  dual_port_ram #(.RDW_MODE(2), .OUT_REG(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic        busy_w  [3];
  logic        a_vld_w [3];
  logic [31:0] a_dout_w[3];
  logic        b_vld_w [3];
  logic [31:0] b_dout_w[3];
  logic        b_col_w [3];

  assign busy_w[0] = bus0.init_busy;  assign busy_w[1] = bus1.init_busy;  assign busy_w[2] = bus2.init_busy;
  assign a_vld_w[0] = bus0.a_valid;   assign a_vld_w[1] = bus1.a_valid;   assign a_vld_w[2] = bus2.a_valid;
  assign a_dout_w[0] = bus0.a_dout;   assign a_dout_w[1] = bus1.a_dout;   assign a_dout_w[2] = bus2.a_dout;
  assign b_vld_w[0] = bus0.b_valid;   assign b_vld_w[1] = bus1.b_valid;   assign b_vld_w[2] = bus2.b_valid;
  assign b_dout_w[0] = bus0.b_dout;   assign b_dout_w[1] = bus1.b_dout;   assign b_dout_w[2] = bus2.b_dout;
  assign b_col_w[0] = bus0.b_collision; assign b_col_w[1] = bus1.b_collision; assign b_col_w[2] = bus2.b_collision;

  typedef struct {
    logic        a_valid;
    logic [31:0] a_dout;
    logic        b_valid;
    logic [31:0] b_dout;
    logic        b_col;
  } exp_t;

  typedef struct {
    logic        a_en, a_we;
    logic [3:0]  a_be;
    logic [3:0]  a_addr;
    logic [31:0] a_din;
    logic        b_en;
    logic [3:0]  b_addr;
    logic        x_a_valid;
    logic [31:0] x_a_dout;
    logic        x_b_valid;
    logic [31:0] x_b_dout;
    logic        x_b_col;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_m  [16];
  logic [31:0] last_a [3];
  logic [31:0] last_b [3];
  int          busy_cnt;
  exp_t        q0[$], q1[$], q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int d, input exp_t e);
    string p;
    p = $sformatf("u%0d", d);
    check({p, ".a_valid"},     {31'b0, a_vld_w[d]}, {31'b0, e.a_valid});
    check({p, ".a_dout"},      a_dout_w[d],         e.a_dout);
    check({p, ".b_valid"},     {31'b0, b_vld_w[d]}, {31'b0, e.b_valid});
    check({p, ".b_dout"},      b_dout_w[d],         e.b_dout);
    check({p, ".b_collision"}, {31'b0, b_col_w[d]}, {31'b0, e.b_col});
  endtask

  task automatic drive(input logic a_en, input logic a_we, input logic [3:0] a_be,
                       input logic [3:0] a_addr, input logic [31:0] a_din,
                       input logic b_en, input logic [3:0] b_addr);
    bus0.a_en = a_en; bus0.a_we = a_we; bus0.a_be = a_be; bus0.a_addr = a_addr;
    bus0.a_din = a_din; bus0.b_en = b_en; bus0.b_addr = b_addr;
    bus1.a_en = a_en; bus1.a_we = a_we; bus1.a_be = a_be; bus1.a_addr = a_addr;
    bus1.a_din = a_din; bus1.b_en = b_en; bus1.b_addr = b_addr;
    bus2.a_en = a_en; bus2.a_we = a_we; bus2.a_be = a_be; bus2.a_addr = a_addr;
    bus2.a_din = a_din; bus2.b_en = b_en; bus2.b_addr = b_addr;
  endtask

  // One clock of traffic: drive at the falling edge, predict, compare #1
  // after the rising edge.
  task automatic step(input logic a_en, input logic a_we, input logic [3:0] a_be,
                      input logic [3:0] a_addr, input logic [31:0] a_din,
                      input logic b_en, input logic [3:0] b_addr);
    exp_t        e [3];
    exp_t        r;
    logic [31:0] old_w, new_w;
    logic        acc;
    @(negedge clk);
    drive(a_en, a_we, a_be, a_addr, a_din, b_en, b_addr);
    acc = (busy_cnt == 0);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("u%0d.init_busy", d), {31'b0, busy_w[d]}, {31'b0, !acc});
      e[d].a_valid = 1'b0;
      e[d].b_valid = 1'b0;
      e[d].b_col   = 1'b0;
    end
    old_w = mem_m[a_addr];
    for (int l = 0; l < 4; l++)
      new_w[l*8 +: 8] = a_be[l] ? a_din[l*8 +: 8] : old_w[l*8 +: 8];
    if (acc && b_en) begin
      for (int d = 0; d < 3; d++) begin
        last_b[d]    = mem_m[b_addr];
        e[d].b_valid = 1'b1;
        e[d].b_col   = a_en && a_we && (a_addr == b_addr);
      end
    end
    if (acc && a_en) begin
      if (!a_we) begin
        for (int d = 0; d < 3; d++) begin
          last_a[d] = old_w;
          e[d].a_valid = 1'b1;
        end
      end else begin
        last_a[0] = old_w; e[0].a_valid = 1'b1;
        last_a[1] = new_w; e[1].a_valid = 1'b1;
        mem_m[a_addr] = new_w;
      end
    end
    for (int d = 0; d < 3; d++) begin
      e[d].a_dout = last_a[d];
      e[d].b_dout = last_b[d];
    end
    q0.push_back(e[0]);
    q1.push_back(e[1]);
    q2.push_back(e[2]);
    @(posedge clk);
    #1;
    if (busy_cnt > 0) busy_cnt--;
    r = q0.pop_front(); cmp(0, r);
    r = q1.pop_front(); cmp(1, r);
    r = q2.pop_front(); cmp(2, r);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
  endtask

  // Asserts reset mid-cycle, checks reset values, releases just after a
  // rising edge so the next step's edge is clear cycle 1.
  task automatic apply_reset();
    exp_t z;
    #2;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("u%0d.rst_init_busy", d), {31'b0, busy_w[d]},  32'd1);
      check($sformatf("u%0d.rst_a_dout", d),    a_dout_w[d],         32'h0);
      check($sformatf("u%0d.rst_a_valid", d),   {31'b0, a_vld_w[d]}, 32'd0);
      check($sformatf("u%0d.rst_b_dout", d),    b_dout_w[d],         32'h0);
      check($sformatf("u%0d.rst_b_valid", d),   {31'b0, b_vld_w[d]}, 32'd0);
      check($sformatf("u%0d.rst_b_col", d),     {31'b0, b_col_w[d]}, 32'd0);
    end
    #1;
    rst_n = 1'b1;
    busy_cnt = 16;
    for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
    for (int d = 0; d < 3; d++) begin
      last_a[d] = 32'h0;
      last_b[d] = 32'h0;
    end
    q0.delete(); q1.delete(); q2.delete();
    z.a_valid = 1'b0; z.a_dout = 32'h0; z.b_valid = 1'b0; z.b_dout = 32'h0; z.b_col = 1'b0;
    q1.push_back(z);  // registered-output instance lags by one cycle
  endtask

  vec_t        tbl [9];
  logic        cap_v [5];
  logic [31:0] cap_d [5];

  initial begin
    //        a_en  a_we  be     addr   din            b_en  b_addr  xav   xad            xbv   xbd            xcol
    tbl[0] = '{1'b1, 1'b1, 4'hF, 4'd3, 32'hAABBCCDD, 1'b0, 4'd0,  1'b1, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 4'h5, 4'd3, 32'h11223344, 1'b1, 4'd3,  1'b1, 32'hAABBCCDD, 1'b1, 32'hAABBCCDD, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 4'h0, 4'd3, 32'h00000000, 1'b1, 4'd3,  1'b1, 32'hAA22CC44, 1'b1, 32'hAA22CC44, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 4'hF, 4'd5, 32'h12345678, 1'b0, 4'd0,  1'b1, 32'h00000000, 1'b0, 32'hAA22CC44, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 4'hF, 4'd5, 32'hCAFEF00D, 1'b1, 4'd5,  1'b1, 32'h12345678, 1'b1, 32'h12345678, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 4'hF, 4'd7, 32'hDEADBEEF, 1'b1, 4'd7,  1'b1, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 4'h0, 4'd0, 32'h00000000, 1'b1, 4'd7,  1'b0, 32'h00000000, 1'b1, 32'hDEADBEEF, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 4'h0, 4'd9, 32'h55667788, 1'b1, 4'd10, 1'b1, 32'h00000000, 1'b1, 32'h00000000, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 4'h0, 4'd9, 32'h00000000, 1'b1, 4'd5,  1'b1, 32'h00000000, 1'b1, 32'hCAFEF00D, 1'b0};

    drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    apply_reset();

    // Clear phase: requests are offered but must be ignored for 16 cycles
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 4'hF, 4'(i), 32'hFFFF0000, 1'b1, 4'(i));
    // Every address reads back zero after the clear
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(i));

    // Vector table: byte merge, RDW, collision, no-op write
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].a_en, tbl[i].a_we, tbl[i].a_be, tbl[i].a_addr, tbl[i].a_din,
           tbl[i].b_en, tbl[i].b_addr);
      check($sformatf("tbl%0d.a_valid", i), {31'b0, bus0.a_valid},     {31'b0, tbl[i].x_a_valid});
      check($sformatf("tbl%0d.a_dout", i),  bus0.a_dout,               tbl[i].x_a_dout);
      check($sformatf("tbl%0d.b_valid", i), {31'b0, bus0.b_valid},     {31'b0, tbl[i].x_b_valid});
      check($sformatf("tbl%0d.b_dout", i),  bus0.b_dout,               tbl[i].x_b_dout);
      check($sformatf("tbl%0d.b_col", i),   {31'b0, bus0.b_collision}, {31'b0, tbl[i].x_b_col});
    end

    // Registered-output pipeline: back-to-back B reads of 0,1,2
    step(1'b1, 1'b1, 4'hF, 4'd0, 32'h0000A000, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'hF, 4'd1, 32'h0000A001, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'hF, 4'd2, 32'h0000A002, 1'b0, 4'd0);
    idle_step();
    idle_step();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(i));
      else       idle_step();
      cap_v[i] = bus1.b_valid;
      cap_d[i] = bus1.b_dout;
    end
    check("pipe.v0", {31'b0, cap_v[0]}, 32'd0);
    check("pipe.v1", {31'b0, cap_v[1]}, 32'd1);
    check("pipe.d1", cap_d[1], 32'h0000A000);
    check("pipe.v2", {31'b0, cap_v[2]}, 32'd1);
    check("pipe.d2", cap_d[2], 32'h0000A001);
    check("pipe.v3", {31'b0, cap_v[3]}, 32'd1);
    check("pipe.d3", cap_d[3], 32'h0000A002);
    check("pipe.v4", {31'b0, cap_v[4]}, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), $urandom(), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)));
    end

    // Reset in the middle of a clear restarts the full 16-cycle sequence
    apply_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 4'hF, 4'd2, 32'h0BADF00D, 1'b1, 4'd2);
    apply_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 4'hF, 4'd2, 32'h0BADF00D, 1'b1, 4'd2);
    step(1'b1, 1'b0, 4'h0, 4'd2, 32'h0, 1'b1, 4'd2);
    check("midclear.a_dout", bus0.a_dout, 32'h0);
    check("midclear.b_valid", {31'b0, bus0.b_valid}, 32'd1);
    idle_step();
    idle_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dual_port_ram.md
# dual_port_ram

Parametrised synchronous RAM with one read/write port (A) and one read-only port (B), both on a single clock. It adds per-byte write enables, a selectable read-during-write mode, an optional output register stage, read-valid flags, cross-port collision reporting, and a hardware clear sequence after reset. It is the general-purpose storage primitive for buffers and register files elsewhere in the design.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH
- BYTE_WIDTH, 8, bits per byte lane; NB = DATA_WIDTH/BYTE_WIDTH
- RDW_MODE, 0, port A read-during-write behaviour: 0 = read-first, 1 = write-first, 2 = no-change
- OUT_REG, 0, 1 adds one output pipeline register on both ports
- CLEAR_ON_RESET, 1, 1 zero-fills the whole array after reset
- clk  in  1  single clock; all logic is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- init_busy  out  1  high while the clear sequence runs; requests are ignored while high
- a_en  in  1  port A access enable
- a_we  in  1  port A write (qualified by a_en)
- a_be  in  NB  port A byte-lane write enables
- a_addr  in  ADDR_WIDTH  port A address
- a_din  in  DATA_WIDTH  port A write data
- a_dout  out  DATA_WIDTH  port A read data
- a_valid  out  1  a_dout is valid this cycle (one-cycle pulse)
- b_en  in  1  port B read enable
- b_addr  in  ADDR_WIDTH  port B address
- b_dout  out  DATA_WIDTH  port B read data
- b_valid  out  1  b_dout is valid this cycle (one-cycle pulse)
- b_collision  out  1  qualifies b_valid: B read an address that A wrote in the same cycle

## Operation
- Reset (rst_n=0), asynchronous: a_dout, b_dout, a_valid, b_valid, b_collision and pipeline registers go to 0. init_busy goes to CLEAR_ON_RESET. The clear counter goes to 0. Array contents are not reset directly.
- FSM states:
  - CLEAR: writes 0 to address cnt each cycle and increments cnt. After writing DEPTH-1, moves to RUN and drops init_busy.
  - RUN: normal operation.
  - If CLEAR_ON_RESET=0, the FSM leaves reset directly in RUN.
  - Reset asserted mid-CLEAR restarts the clear from address 0.
- In CLEAR, a_en and b_en are ignored: no writes, no valids.
- Port A write (a_en=1, a_we=1): for each lane i with a_be[i]=1, bits [i*BYTE_WIDTH +: BYTE_WIDTH] of mem[a_addr] take a_din. Other lanes keep their values. a_be=0 is a no-op write, but still follows RDW_MODE for the read side.
- Port A read-during-write:
  - RDW_MODE 0: a_dout = word before the write; a_valid=1.
  - RDW_MODE 1: a_dout = merged post-write word; a_valid=1.
  - RDW_MODE 2: a_dout holds; a_valid=0.
- Port A read (a_en=1, a_we=0): a_dout = mem[a_addr]; a_valid=1.
- Port B read (b_en=1): b_dout = mem[b_addr]; b_valid=1.
- Cross-port collision: port A writes address X while port B reads X in the same cycle.
  - B returns the pre-write word (read-first).
  - b_collision=1 together with that b_valid.
  - The write completes normally.
- Idle port (en=0): dout holds its last value; valid=0.

## Timing
- Read latency: 1 + OUT_REG cycles from the request edge to dout/valid. With OUT_REG=1, valid and collision are delayed alongside data.
- Throughput: one access per port per cycle, with back-to-back addresses allowed.
- A write is visible to either port's read one cycle after the write edge.
- The clear takes exactly DEPTH cycles after rst_n rises. With defaults, init_busy is high for 16 cycles and the first accepted request is on cycle 17.
- valid and collision are single-cycle pulses per request and are never high without a matching request.

## Test plan
- Reset, then clear (defaults): release rst_n -> init_busy high 16 cycles; a B read at every address afterwards returns 0x00000000 with b_valid one cycle later.
- Byte-enable merge: write 0xAABBCCDD to addr 3 with be=1111, then 0x11223344 with be=0101 -> B read of addr 3 returns 0xAA22CC44.
- RDW modes: addr 5 holds 0x12345678; write 0xCAFEF00D be=1111 with a_en=1 -> a_dout = 0x12345678 (mode 0), 0xCAFEF00D (mode 1), or unchanged with a_valid=0 (mode 2).
- Collision: same cycle, A writes 0xDEADBEEF to addr 7 (old 0x0) and B reads addr 7 -> b_dout=0x00000000, b_valid=1, b_collision=1; the next B read returns 0xDEADBEEF with b_collision=0.
- OUT_REG=1 pipeline: B reads of addrs 0,1,2 on consecutive cycles -> data appears on cycles +2,+3,+4 in order, with b_valid high for 3 consecutive cycles.
- Reset mid-clear: assert rst_n=0 at clear cycle 8 and release -> init_busy high for a full 16 cycles again; no request is accepted during that time.
